// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types for the cache fill controller: FSM state encoding and PLRU sizing.
package cache_fill_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_REQ  = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_UPDATE   = 3'd3,
        ST_FLUSH    = 3'd4
    } fill_state_e;

    // A binary tree over N ways has N-1 internal nodes.
    function automatic int plru_width(input int ways);
        return ways - 1;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_plru.sv
// Per-set tree pseudo-LRU state: combinational victim read, hit and fill touch
// ports (fill wins when both hit the same set) and a per-set clear.
module cache_fill_ctrl_plru
    import cache_fill_ctrl_pkg::*;
#(
    parameter int NUM_WAYS     = 4,
    parameter int NUM_SETS     = 16,
    parameter int NUM_WAYS_LOG = $clog2(NUM_WAYS),
    parameter int NUM_SETS_LOG = $clog2(NUM_SETS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SETS_LOG-1:0] rd_set_idx,
    output logic [NUM_WAYS_LOG-1:0] victim_way_idx,
    input  logic                    hit_en,
    input  logic [NUM_SETS_LOG-1:0] hit_set_idx,
    input  logic [NUM_WAYS_LOG-1:0] hit_way_idx,
    input  logic                    fill_en,
    input  logic [NUM_SETS_LOG-1:0] fill_set_idx,
    input  logic [NUM_WAYS_LOG-1:0] fill_way_idx,
    input  logic                    clr_en,
    input  logic [NUM_SETS_LOG-1:0] clr_set_idx
);

    localparam int PLRU_W = plru_width(NUM_WAYS);

    logic [PLRU_W-1:0] plru_r [NUM_SETS];

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right);
    // a node bit of 1 means the victim lies in the right subtree.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [NUM_WAYS_LOG-1:0] way);
        logic [PLRU_W-1:0]       res;
        logic [NUM_WAYS_LOG-1:0] way_sh;
        logic                    dir;
        int                      node;
        res    = bits;
        way_sh = way;
        node   = 0;
        for (int lvl = 0; lvl < NUM_WAYS_LOG; lvl++) begin
            dir    = way_sh[NUM_WAYS_LOG-1];
            way_sh = way_sh << 1;
            for (int n = 0; n < PLRU_W; n++) begin
                res[n] = (n == node) ? ~dir : res[n];
            end
            node = 2 * node + (dir ? 2 : 1);
        end
        return res;
    endfunction

    function automatic logic [NUM_WAYS_LOG-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [NUM_WAYS_LOG-1:0] way;
        logic                    bit_v;
        int                      node;
        way  = '0;
        node = 0;
        for (int lvl = 0; lvl < NUM_WAYS_LOG; lvl++) begin
            bit_v = 1'b0;
            for (int n = 0; n < PLRU_W; n++) begin
                bit_v = (n == node) ? bits[n] : bit_v;
            end
            way  = (way << 1) | NUM_WAYS_LOG'(bit_v);
            node = 2 * node + (bit_v ? 2 : 1);
        end
        return way;
    endfunction

    assign victim_way_idx = plru_victim(plru_r[rd_set_idx]);

    // Tree state update: clear beats fill beats hit within one set; distinct sets update independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_r[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (clr_en && (clr_set_idx == NUM_SETS_LOG'(s))) begin
                    plru_r[s] <= '0;
                end else if (fill_en && (fill_set_idx == NUM_SETS_LOG'(s))) begin
                    plru_r[s] <= plru_touch(plru_r[s], fill_way_idx);
                end else if (hit_en && (hit_set_idx == NUM_SETS_LOG'(s))) begin
                    plru_r[s] <= plru_touch(plru_r[s], hit_way_idx);
                end else begin
                    plru_r[s] <= plru_r[s];
                end
            end
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss/fill sequencer and sole owner of the tag-array update port; also walks
// the whole array to invalidate it on a flush request.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int NUM_WAYS        = 4,
    parameter int NUM_SETS        = 16,
    parameter int CACHE_TAG_WIDTH = 22,
    parameter int NUM_WAYS_LOG    = $clog2(NUM_WAYS),
    parameter int NUM_SETS_LOG    = $clog2(NUM_SETS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [NUM_SETS_LOG-1:0]    miss_set_idx,
    input  logic [CACHE_TAG_WIDTH-1:0] miss_tag,
    input  logic                       hit_en,
    input  logic [NUM_SETS_LOG-1:0]    hit_set_idx,
    input  logic [NUM_WAYS_LOG-1:0]    hit_way_idx,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [NUM_SETS_LOG-1:0]    mem_req_set_idx,
    output logic [CACHE_TAG_WIDTH-1:0] mem_req_tag,
    output logic [NUM_WAYS_LOG-1:0]    mem_req_way_idx,
    input  logic                       mem_resp_valid,
    output logic                       update_en,
    output logic [NUM_WAYS_LOG-1:0]    update_way_idx,
    output logic [NUM_SETS_LOG-1:0]    update_set_idx,
    output logic [CACHE_TAG_WIDTH-1:0] update_tag,
    output logic                       update_valid,
    output logic                       fill_done,
    output logic [NUM_WAYS_LOG-1:0]    fill_way_idx,
    output logic                       busy
);

    localparam int CNT_W = NUM_SETS_LOG + NUM_WAYS_LOG;

    fill_state_e                         state_r, next_state_s;
    logic                                active_r;
    logic                                idle_ok_s, miss_accept_s, flush_start_s;
    logic [NUM_SETS_LOG-1:0]             set_r;
    logic [CACHE_TAG_WIDTH-1:0]          tag_r;
    logic [NUM_WAYS_LOG-1:0]             way_r;
    logic [CNT_W-1:0]                    flush_cnt_r, flush_cnt_next_s;
    logic                                flush_last_s;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   shadow_r;
    logic                                inv_found_s;
    logic [NUM_WAYS_LOG-1:0]             inv_way_s, plru_victim_s, victim_s;
    logic [NUM_SETS_LOG-1:0]             cur_set_s;
    logic [CACHE_TAG_WIDTH-1:0]          cur_tag_s;
    logic [NUM_WAYS_LOG-1:0]             cur_way_s;

    logic                                mem_req_valid_s, mem_req_valid_r;
    logic [NUM_SETS_LOG-1:0]             mem_req_set_s, mem_req_set_r;
    logic [CACHE_TAG_WIDTH-1:0]          mem_req_tag_s, mem_req_tag_r;
    logic [NUM_WAYS_LOG-1:0]             mem_req_way_s, mem_req_way_r;
    logic                                update_en_s, update_en_r;
    logic [NUM_WAYS_LOG-1:0]             update_way_s, update_way_r;
    logic [NUM_SETS_LOG-1:0]             update_set_s, update_set_r;
    logic [CACHE_TAG_WIDTH-1:0]          update_tag_s, update_tag_r;
    logic                                update_valid_s, update_valid_r;
    logic                                fill_done_s, fill_done_r;
    logic [NUM_WAYS_LOG-1:0]             fill_way_s, fill_way_r;
    logic                                flush_done_s, flush_done_r;

    // active_r keeps miss_ready low while in reset and for the first cycle after.
    assign idle_ok_s     = active_r && (state_r == ST_IDLE);
    assign miss_ready    = idle_ok_s && !flush_req;
    assign flush_start_s = idle_ok_s && flush_req;
    assign miss_accept_s = miss_ready && miss_valid;
    assign busy          = (state_r != ST_IDLE);
    assign flush_last_s  = &flush_cnt_r;

    cache_fill_ctrl_plru #(
        .NUM_WAYS     (NUM_WAYS),
        .NUM_SETS     (NUM_SETS),
        .NUM_WAYS_LOG (NUM_WAYS_LOG),
        .NUM_SETS_LOG (NUM_SETS_LOG)
    ) u_plru (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_set_idx     (miss_set_idx),
        .victim_way_idx (plru_victim_s),
        .hit_en         (hit_en && (state_r != ST_FLUSH)),
        .hit_set_idx    (hit_set_idx),
        .hit_way_idx    (hit_way_idx),
        .fill_en        (state_r == ST_UPDATE),
        .fill_set_idx   (set_r),
        .fill_way_idx   (way_r),
        .clr_en         ((state_r == ST_FLUSH) && (flush_cnt_r[NUM_WAYS_LOG-1:0] == '0)),
        .clr_set_idx    (flush_cnt_r[CNT_W-1:NUM_WAYS_LOG])
    );

    // Victim choice: lowest-index invalid way, otherwise the PLRU pick.
    always_comb begin
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!shadow_r[miss_set_idx][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = NUM_WAYS_LOG'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        victim_s = inv_found_s ? inv_way_s : plru_victim_s;
    end

    // Request fields come straight from the miss port on the accept edge, from the latches after.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_set_s = miss_set_idx;
            cur_tag_s = miss_tag;
            cur_way_s = victim_s;
        end else begin
            cur_set_s = set_r;
            cur_tag_s = tag_r;
            cur_way_s = way_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            active_r <= 1'b1;
        end
    end

    // Next-state logic; flush_req outranks a concurrent miss.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_start_s) begin
                    next_state_s = ST_FLUSH;
                end else if (miss_accept_s) begin
                    next_state_s = ST_MEM_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MEM_REQ:  next_state_s = mem_req_ready ? ST_MEM_WAIT : ST_MEM_REQ;
            ST_MEM_WAIT: next_state_s = mem_resp_valid ? ST_UPDATE : ST_MEM_WAIT;
            ST_UPDATE:   next_state_s = ST_IDLE;
            ST_FLUSH:    next_state_s = flush_last_s ? ST_IDLE : ST_FLUSH;
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // Flush walk position for the next cycle: set-major, way-minor.
    always_comb begin
        if (flush_start_s) begin
            flush_cnt_next_s = '0;
        end else if (state_r == ST_FLUSH) begin
            flush_cnt_next_s = flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_next_s = flush_cnt_r;
        end
    end

    // Output decode: values for the registered outputs, keyed on the state being entered.
    always_comb begin
        mem_req_valid_s = 1'b0;
        mem_req_set_s   = '0;
        mem_req_tag_s   = '0;
        mem_req_way_s   = '0;
        update_en_s     = 1'b0;
        update_way_s    = '0;
        update_set_s    = '0;
        update_tag_s    = '0;
        update_valid_s  = 1'b0;
        fill_done_s     = 1'b0;
        fill_way_s      = '0;
        flush_done_s    = 1'b0;
        case (next_state_s)
            ST_MEM_REQ: begin
                mem_req_valid_s = 1'b1;
                mem_req_set_s   = cur_set_s;
                mem_req_tag_s   = cur_tag_s;
                mem_req_way_s   = cur_way_s;
            end
            ST_UPDATE: begin
                update_en_s    = 1'b1;
                update_valid_s = 1'b1;
                update_set_s   = set_r;
                update_way_s   = way_r;
                update_tag_s   = tag_r;
                fill_done_s    = 1'b1;
                fill_way_s     = way_r;
            end
            ST_FLUSH: begin
                update_en_s  = 1'b1;
                update_set_s = flush_cnt_next_s[CNT_W-1:NUM_WAYS_LOG];
                update_way_s = flush_cnt_next_s[NUM_WAYS_LOG-1:0];
            end
            ST_IDLE:     flush_done_s = (state_r == ST_FLUSH);
            default:     flush_done_s = 1'b0;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_valid_r <= 1'b0;
            mem_req_set_r   <= '0;
            mem_req_tag_r   <= '0;
            mem_req_way_r   <= '0;
            update_en_r     <= 1'b0;
            update_way_r    <= '0;
            update_set_r    <= '0;
            update_tag_r    <= '0;
            update_valid_r  <= 1'b0;
            fill_done_r     <= 1'b0;
            fill_way_r      <= '0;
            flush_done_r    <= 1'b0;
        end else begin
            mem_req_valid_r <= mem_req_valid_s;
            mem_req_set_r   <= mem_req_set_s;
            mem_req_tag_r   <= mem_req_tag_s;
            mem_req_way_r   <= mem_req_way_s;
            update_en_r     <= update_en_s;
            update_way_r    <= update_way_s;
            update_set_r    <= update_set_s;
            update_tag_r    <= update_tag_s;
            update_valid_r  <= update_valid_s;
            fill_done_r     <= fill_done_s;
            fill_way_r      <= fill_way_s;
            flush_done_r    <= flush_done_s;
        end
    end

    // Miss latches and flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_r       <= '0;
            tag_r       <= '0;
            way_r       <= '0;
            flush_cnt_r <= '0;
        end else begin
            set_r       <= cur_set_s;
            tag_r       <= cur_tag_s;
            way_r       <= cur_way_s;
            flush_cnt_r <= flush_cnt_next_s;
        end
    end

    // Shadow valid bitmap mirrors what has been written to the tag array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= '0;
        end else if (state_r == ST_UPDATE) begin
            shadow_r[set_r][way_r] <= 1'b1;
        end else if (state_r == ST_FLUSH) begin
            shadow_r[flush_cnt_r[CNT_W-1:NUM_WAYS_LOG]][flush_cnt_r[NUM_WAYS_LOG-1:0]] <= 1'b0;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign mem_req_valid   = mem_req_valid_r;
    assign mem_req_set_idx = mem_req_set_r;
    assign mem_req_tag     = mem_req_tag_r;
    assign mem_req_way_idx = mem_req_way_r;
    assign update_en       = update_en_r;
    assign update_way_idx  = update_way_r;
    assign update_set_idx  = update_set_r;
    assign update_tag      = update_tag_r;
    assign update_valid    = update_valid_r;
    assign fill_done       = fill_done_r;
    assign fill_way_idx    = fill_way_r;
    assign flush_done      = flush_done_r;

endmodule
